// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider.
//   - default operand width and retire rate
//   - FSM state encodings
//   - helpers for the iteration count, counter width and operand magnitude
package div_pkg;

    localparam int DIV_DATA_WIDTH     = 32;
    localparam int DIV_BITS_PER_CYCLE = 1;
    // Widest operand abs_mag() can handle.
    localparam int DIV_MAX_W          = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } div_state_e;

    // K: number of clocks spent in ITER.
    function automatic int div_iter_count(input int data_width, input int bits_per_cycle);
        return data_width / bits_per_cycle;
    endfunction

    // Counter wide enough to hold K itself.
    function automatic int div_cnt_width(input int k);
        return $clog2(k + 1);
    endfunction

    // Magnitude of a width-bit value: two's-complement abs when signed_en=1,
    // raw value otherwise. abs(MIN) wraps to MIN, which is the correct
    // unsigned magnitude.
    function automatic logic [DIV_MAX_W-1:0] abs_mag(input logic [DIV_MAX_W-1:0] value,
                                                     input int unsigned         width,
                                                     input logic                signed_en);
        if (signed_en && value[width-1])
            return ~value + 1'b1;
        return value;
    endfunction

endpackage

// File: rtl/nonres_div_step.sv
// One combinational non-restoring division step.
//   a_i  : partial remainder A (DATA_WIDTH+1 bits, two's complement)
//   qr_i : quotient/dividend shift register
//   m_i  : divisor magnitude
//   a_o  : A after shift and add/subtract
//   qr_o : shifted quotient register with the new quotient bit in bit 0
module nonres_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   a_i,
    input  logic [DATA_WIDTH-1:0] qr_i,
    input  logic [DATA_WIDTH-1:0] m_i,
    output logic [DATA_WIDTH:0]   a_o,
    output logic [DATA_WIDTH-1:0] qr_o
);

    logic [DATA_WIDTH:0] a_sh;

    always_comb begin
        a_sh = {a_i[DATA_WIDTH-1:0], qr_i[DATA_WIDTH-1]};
        // The shifted value can exceed DATA_WIDTH+1 signed bits, so the
        // add/subtract decision uses the sign of A before the shift. The
        // modular result lands back in range after the add/subtract.
        if (a_i[DATA_WIDTH])
            a_o = a_sh + {1'b0, m_i};
        else
            a_o = a_sh - {1'b0, m_i};
        qr_o = {qr_i[DATA_WIDTH-2:0], ~a_o[DATA_WIDTH]};
    end

endmodule

// File: rtl/seq_nonres_divider.sv
// Multi-cycle non-restoring divider, BITS_PER_CYCLE quotient bits per clock.
//   clock, clear (async, active high)
//   start, signed_en, Q (dividend), M (divisor) : request, sampled on accept
//   busy      : accept until the done cycle
//   done      : one-cycle result pulse
//   Z         : {remainder, quotient}, held until the next result
//   div_zero  : M==0 on the last operation
//   ovf       : signed MIN/-1 on the last operation
// Optional macro SEQ_DIV_EARLY_EXIT_EN: when |Q| < |M| the operation skips
// ITER and finishes with Q=0, R=dividend.
//
//   state | meaning
//   IDLE  | waiting for start; results held
//   ITER  | K clocks of BITS_PER_CYCLE non-restoring steps
//   FIX   | remainder correction, sign fix-up, result write
module seq_nonres_divider
    import div_pkg::*;
#(
    parameter int DATA_WIDTH     = DIV_DATA_WIDTH,
    parameter int BITS_PER_CYCLE = DIV_BITS_PER_CYCLE
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    signed_en,
    input  logic [DATA_WIDTH-1:0]   Q,
    input  logic [DATA_WIDTH-1:0]   M,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] Z,
    output logic                    div_zero,
    output logic                    ovf
);

    localparam int K     = div_iter_count(DATA_WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = div_cnt_width(K);

    div_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH:0]     a_q, a_d;
    logic [DATA_WIDTH-1:0]   qr_q, qr_d;
    logic [DATA_WIDTH-1:0]   mmag_q, mmag_d;
    logic                    qs_q, qs_d, ms_q, ms_d;
    logic                    zero_q, zero_d, ovfp_q, ovfp_d;
    logic [2*DATA_WIDTH-1:0] z_q, z_d;
    logic                    done_q, done_d, dz_q, dz_d, ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0]   q_mag, m_mag, rem_mag, quo_fix, rem_fix;
    logic                    m_zero, early;

    logic [DATA_WIDTH:0]     a_chain  [BITS_PER_CYCLE+1];
    logic [DATA_WIDTH-1:0]   qr_chain [BITS_PER_CYCLE+1];

    assign a_chain[0]  = a_q;
    assign qr_chain[0] = qr_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        nonres_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
            .a_i  (a_chain[i]),
            .qr_i (qr_chain[i]),
            .m_i  (mmag_q),
            .a_o  (a_chain[i+1]),
            .qr_o (qr_chain[i+1])
        );
    end

    always_comb begin
        q_mag  = DATA_WIDTH'(abs_mag(DIV_MAX_W'(Q), DATA_WIDTH, signed_en));
        m_mag  = DATA_WIDTH'(abs_mag(DIV_MAX_W'(M), DATA_WIDTH, signed_en));
        m_zero = (M == '0);
`ifdef SEQ_DIV_EARLY_EXIT_EN
        early  = !m_zero && (q_mag < m_mag);
`else
        early  = 1'b0;
`endif
        // Final correction of a negative partial remainder, then sign fix-up.
        rem_mag = a_q[DATA_WIDTH] ? a_q[DATA_WIDTH-1:0] + mmag_q : a_q[DATA_WIDTH-1:0];
        quo_fix = (qs_q ^ ms_q) ? -qr_q : qr_q;
        rem_fix = qs_q ? -rem_mag : rem_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        qr_d    = qr_q;
        mmag_d  = mmag_q;
        qs_d    = qs_q;
        ms_d    = ms_q;
        zero_d  = zero_q;
        ovfp_d  = ovfp_q;
        z_d     = z_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mmag_d = m_mag;
                    qs_d   = Q[DATA_WIDTH-1] & signed_en;
                    ms_d   = M[DATA_WIDTH-1] & signed_en;
                    zero_d = m_zero;
                    ovfp_d = signed_en && (Q == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (M == '1);
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                    // Early exit preloads the finished state: quotient 0,
                    // remainder equal to the dividend magnitude.
                    a_d    = early ? {1'b0, q_mag} : '0;
                    qr_d   = early ? '0 : q_mag;
                    if (m_zero || early) begin
                        // Fast paths hold FIX one extra clock so the minimum
                        // accept-to-done turnaround is two edges.
                        state_d = S_FIX;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = S_ITER;
                        cnt_d   = CNT_W'(K);
                    end
                end
            end
            S_ITER: begin
                a_d   = a_chain[BITS_PER_CYCLE];
                qr_d  = qr_chain[BITS_PER_CYCLE];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    dz_d    = zero_q;
                    ovf_d   = ovfp_q;
                    // On divide by zero qr_q still holds the dividend magnitude.
                    z_d     = zero_q ? {qr_q, {DATA_WIDTH{1'b1}}} : {rem_fix, quo_fix};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            qr_q    <= '0;
            mmag_q  <= '0;
            qs_q    <= 1'b0;
            ms_q    <= 1'b0;
            zero_q  <= 1'b0;
            ovfp_q  <= 1'b0;
            z_q     <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            mmag_q  <= mmag_d;
            qs_q    <= qs_d;
            ms_q    <= ms_d;
            zero_q  <= zero_d;
            ovfp_q  <= ovfp_d;
            z_q     <= z_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign Z        = z_q;
    assign div_zero = dz_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_seq_nonres_divider.sv
// Bench for seq_nonres_divider: instance 0 uses the default parameters,
// instance 1 retires four quotient bits per clock. Expected results come
// from a behavioural model using the language divide operators.
module tb_seq_nonres_divider;

`ifdef SEQ_DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [63:0] z;
        logic        dz;
        logic        ov;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear;
    logic        start_v [2];
    logic        sgn_v   [2];
    logic [31:0] q_v     [2];
    logic [31:0] m_v     [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic [63:0] z_v     [2];
    logic        dz_v    [2];
    logic        ov_v    [2];

    exp_t sb[$];
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    seq_nonres_divider #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clock(clock), .clear(clear), .start(start_v[0]), .signed_en(sgn_v[0]),
        .Q(q_v[0]), .M(m_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .Z(z_v[0]), .div_zero(dz_v[0]), .ovf(ov_v[0])
    );

    seq_nonres_divider #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clock(clock), .clear(clear), .start(start_v[1]), .signed_en(sgn_v[1]),
        .Q(q_v[1]), .M(m_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .Z(z_v[1]), .div_zero(dz_v[1]), .ovf(ov_v[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [31:0] q,
                                   input logic [31:0] m, input int k);
        exp_t        e;
        logic [31:0] qm, mm, quo, rem;
        qm = (s && q[31]) ? -q : q;
        mm = (s && m[31]) ? -m : m;
        if (m == 32'd0) begin
            e.z   = {qm, 32'hFFFF_FFFF};
            e.dz  = 1'b1;
            e.ov  = 1'b0;
            e.lat = 2;
        end else begin
            quo = qm / mm;
            rem = qm % mm;
            if (s && (q[31] ^ m[31])) quo = -quo;
            if (s && q[31])           rem = -rem;
            e.z   = {rem, quo};
            e.dz  = 1'b0;
            e.ov  = s && (q == 32'h8000_0000) && (m == 32'hFFFF_FFFF);
            e.lat = (EARLY && qm < mm) ? 2 : k + 1;
        end
        return e;
    endfunction

    // Runs one operation on instance u; poke fires a stray start mid-operation.
    task automatic do_op(input int u, input logic s, input logic [31:0] q,
                         input logic [31:0] m, input bit poke);
        exp_t e;
        int   n;
        bit   busy_ok;
        sb.push_back(model(s, q, m, (u == 0) ? 32 : 8));
        @(negedge clock);
        start_v[u] = 1'b1; sgn_v[u] = s; q_v[u] = q; m_v[u] = m;
        @(posedge clock); #1;
        start_v[u] = 1'b0;
        chk("busy_at_accept", 64'(busy_v[u]), 64'd1);
        chk("flags_clr_at_accept", {61'd0, done_v[u], dz_v[u], ov_v[u]}, 64'd0);
        n = 0;
        busy_ok = 1'b1;
        while (done_v[u] !== 1'b1 && n < 100) begin
            if (busy_v[u] !== 1'b1) busy_ok = 1'b0;
            if (poke && n == 3) begin
                start_v[u] = 1'b1; q_v[u] = ~q; m_v[u] = 32'd5; sgn_v[u] = ~s;
            end
            @(posedge clock); #1;
            n++;
            start_v[u] = 1'b0;
        end
        e = sb.pop_front();
        chk("latency", 64'(n), 64'(e.lat));
        chk("busy_held", 64'(busy_ok), 64'd1);
        chk("busy_drop_at_done", 64'(busy_v[u]), 64'd0);
        chk("z", z_v[u], e.z);
        chk("div_zero", 64'(dz_v[u]), 64'(e.dz));
        chk("ovf", 64'(ov_v[u]), 64'(e.ov));
        @(posedge clock); #1;
        chk("done_one_cycle", 64'(done_v[u]), 64'd0);
        chk("z_held", z_v[u], e.z);
    endtask

    initial begin
        bit seen_done;
        clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; sgn_v[i] = 1'b0; q_v[i] = '0; m_v[i] = '0;
        end
        #12;
        chk("reset_busy_done", {62'd0, busy_v[0], done_v[0]}, 64'd0);
        chk("reset_z", z_v[0], 64'd0);
        chk("reset_flags", {62'd0, dz_v[0], ov_v[0]}, 64'd0);
        chk("reset_z4", z_v[1], 64'd0);
        @(negedge clock);
        clear = 1'b0;

        do_op(0, 1'b1, 32'd100, 32'd7, 1'b0);
        chk("spec_100_7", z_v[0], {32'd2, 32'd14});
        do_op(0, 1'b1, -32'sd100, 32'd7, 1'b0);
        chk("spec_m100_7", z_v[0], {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        do_op(0, 1'b1, 32'd100, -32'sd7, 1'b0);
        chk("spec_100_m7", z_v[0], {32'd2, 32'hFFFF_FFF2});
        do_op(0, 1'b1, 32'd7, 32'd0, 1'b0);
        chk("spec_div0", z_v[0], {32'd7, 32'hFFFF_FFFF});
        do_op(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("spec_min_m1", z_v[0], {32'd0, 32'h8000_0000});
        do_op(0, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("spec_unsigned", z_v[0], {32'd1, 32'h7FFF_FFFF});
        do_op(0, 1'b1, 32'd3, 32'd7, 1'b0);
        chk("spec_3_7", z_v[0], {32'd3, 32'd0});
        do_op(0, 1'b1, -32'sd3, 32'd7, 1'b0);
        do_op(0, 1'b0, 32'd1000, 32'd10, 1'b1);
        chk("start_while_busy", z_v[0], {32'd0, 32'd100});

        // Clear mid-operation: no done, outputs back to reset values.
        @(negedge clock);
        start_v[0] = 1'b1; sgn_v[0] = 1'b1; q_v[0] = 32'd100; m_v[0] = 32'd7;
        @(posedge clock); #1;
        start_v[0] = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        clear = 1'b1;
        #1;
        chk("clear_busy_done", {62'd0, busy_v[0], done_v[0]}, 64'd0);
        chk("clear_z", z_v[0], 64'd0);
        @(negedge clock);
        clear = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done_v[0] === 1'b1) seen_done = 1'b1;
        end
        chk("no_done_after_clear", 64'(seen_done), 64'd0);
        do_op(0, 1'b1, 32'd9, 32'd3, 1'b0);
        chk("spec_9_3", z_v[0], {32'd0, 32'd3});

        do_op(1, 1'b1, 32'd100, 32'd7, 1'b0);
        chk("bpc4_100_7", z_v[1], {32'd2, 32'd14});
        do_op(1, 1'b1, -32'sd100, 32'd7, 1'b0);
        do_op(1, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(1, 1'b1, 32'd7, 32'd0, 1'b0);
        do_op(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] rq, rm;
            rq = $urandom;
            rm = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            do_op(i % 2, 1'($urandom_range(0, 1)), rq, rm, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
